// File: rtl/icestick_afifo_consumer_pkg.sv
// Shared constants for the Icestick AFIFO bring-up endpoints (producer and consumer).
// Also holds the sequence-checker state encoding and a saturating-count helper.
package icestick_afifo_consumer_pkg;

  // Word width shared with the AFIFO producer; both ends must agree.
  localparam int AFIFO_TEST_W = 12;

  localparam logic [0:0] ST_SEED  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/icestick_afifo_consumer_if.sv
// FIFO read-port bundle between the AFIFO read side (master) and the consumer (slave).
// Handshake: rok is valid and rd is stable while rok=1; r is the pop request, and a word
// transfers on every posedge clk where r=1 and rok=1 (the FIFO pops on that same edge).
interface icestick_afifo_consumer_if
  import icestick_afifo_consumer_pkg::*;
#(
  parameter int W = AFIFO_TEST_W
);
  logic         rok;
  logic [W-1:0] rd;
  logic         r;

  modport master (output rok, output rd, input r);
  modport slave  (input rok, input rd, output r);
endinterface

// File: rtl/icestick_afifo_consumer_seq_checker.sv
// afifo_seq_checker: SEED/CHECK sequence checker that verifies accepted words increment by one,
// capturing the first error and counting errors with saturation.
module afifo_seq_checker
  import icestick_afifo_consumer_pkg::*;
#(
  parameter int W = AFIFO_TEST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         accept,
  input  logic [W-1:0] rd,
  output logic         seen,
  output logic         err,
  output logic [7:0]   err_count,
  output logic [W-1:0] err_exp,
  output logic [W-1:0] err_got,
  output logic [0:0]   state_dbg
);

  logic [0:0]   state_q,     state_d;
  logic [W-1:0] exp_q,       exp_d;
  logic         seen_q,      seen_d;
  logic         err_q,       err_d;
  logic [7:0]   err_count_q, err_count_d;
  logic [W-1:0] err_exp_q,   err_exp_d;
  logic [W-1:0] err_got_q,   err_got_d;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    seen_d      = seen_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    if (accept) begin
      case (state_q)
        ST_SEED: begin
          exp_d   = rd + 1'b1;
          seen_d  = 1'b1;
          state_d = ST_CHECK;
        end
        default: begin
          if (rd == exp_q) begin
            exp_d = exp_q + 1'b1;
          end else begin
            err_d       = 1'b1;
            err_count_d = sat_inc8(err_count_q);
            if (!err_q) begin
              err_exp_d = exp_q;
              err_got_d = rd;
            end
            // Resync on the received word so a single drop is one error, not a burst.
            exp_d = rd + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEED;
      exp_q       <= '0;
      seen_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign seen      = seen_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/icestick_afifo_consumer.sv
// Read-side AFIFO test endpoint: paces pops, checks the incrementing sequence and
// drives word-count / heartbeat status for LEDs or a logic analyser.
module icestick_afifo_consumer
  import icestick_afifo_consumer_pkg::*;
#(
  parameter int W         = AFIFO_TEST_W,
  parameter int PACE_LOG2 = 0,
  parameter int HB_LOG2   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  icestick_afifo_consumer_if.slave        fifo,
  output logic                            seen,
  output logic                            err,
  output logic [7:0]                      errCount,
  output logic [W-1:0]                    errExp,
  output logic [W-1:0]                    errGot,
  output logic [15:0]                     wordCount,
  output logic                            heartbeat,
  output logic [0:0]                      dbg_state
);

  logic        pace_hit;
  logic        hb_hit;
  logic        accept;
  logic [15:0] word_count_q, word_count_d;
  logic        heartbeat_q,  heartbeat_d;

  if (PACE_LOG2 == 0) begin : g_no_pace
    assign pace_hit = 1'b1;
  end else begin : g_pace
    logic [PACE_LOG2-1:0] pace_q, pace_d;
    // Free-running: pops do not realign the pace window.
    always_comb pace_d = pace_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pace_q <= '0;
      else        pace_q <= pace_d;
    end
    assign pace_hit = &pace_q;
  end

  // rst_n in the gate drops the pop strobe the instant reset asserts.
  assign fifo.r = fifo.rok & pace_hit & rst_n;
  assign accept = fifo.r;

  always_comb begin
    word_count_d = word_count_q;
    if (accept) word_count_d = word_count_q + 16'd1;
  end

  if (HB_LOG2 == 0) begin : g_hb_every
    assign hb_hit = 1'b1;
  end else begin : g_hb_div
    assign hb_hit = (word_count_d[HB_LOG2-1:0] == '0);
  end

  always_comb begin
    heartbeat_d = heartbeat_q;
    if (accept && hb_hit) heartbeat_d = ~heartbeat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= 16'd0;
      heartbeat_q  <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      heartbeat_q  <= heartbeat_d;
    end
  end

  afifo_seq_checker #(.W(W)) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .rd        (fifo.rd),
    .seen      (seen),
    .err       (err),
    .err_count (errCount),
    .err_exp   (errExp),
    .err_got   (errGot),
    .state_dbg (dbg_state)
  );

  assign wordCount = word_count_q;
  assign heartbeat = heartbeat_q;

endmodule

// File: tb/tb_icestick_afifo_consumer.sv
// Bench for icestick_afifo_consumer: directed vector table, paced instance, saturation,
// mid-stream reset and a randomized stream checked against a history-based reference model.
module tb_icestick_afifo_consumer;

  localparam int W = 12;

  logic clk;
  logic rst_n;

  icestick_afifo_consumer_if #(.W(W)) if0 ();
  icestick_afifo_consumer_if #(.W(W)) if1 ();

  logic         seen0, err0, hb0, seen1, err1, hb1;
  logic [7:0]   cnt0, cnt1;
  logic [W-1:0] eexp0, egot0, eexp1, egot1;
  logic [15:0]  wc0, wc1;
  logic [0:0]   st0, st1;

  icestick_afifo_consumer #(.W(W), .PACE_LOG2(0), .HB_LOG2(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo(if0.slave),
    .seen(seen0), .err(err0), .errCount(cnt0), .errExp(eexp0), .errGot(egot0),
    .wordCount(wc0), .heartbeat(hb0), .dbg_state(st0)
  );

  icestick_afifo_consumer #(.W(W), .PACE_LOG2(2), .HB_LOG2(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo(if1.slave),
    .seen(seen1), .err(err1), .errCount(cnt1), .errExp(eexp1), .errGot(egot1),
    .wordCount(wc1), .heartbeat(hb1), .dbg_state(st1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];   // every word accepted by dut0 since its last reset

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Status derived from the accepted-word history: an error is any word that is not its
  // predecessor plus one; the heartbeat is the parity of completed 256-word blocks.
  task automatic model_eval(output logic m_seen, output logic m_err, output logic [7:0] m_cnt,
                            output logic [W-1:0] m_exp, output logic [W-1:0] m_got,
                            output logic [15:0] m_wc, output logic m_hb);
    int n;
    logic [W-1:0] want;
    n = 0;
    m_exp = '0;
    m_got = '0;
    for (int i = 1; i < exp_q.size(); i++) begin
      want = exp_q[i-1] + 12'd1;
      if (exp_q[i] != want) begin
        if (n == 0) begin
          m_exp = want;
          m_got = exp_q[i];
        end
        n++;
      end
    end
    m_seen = (exp_q.size() > 0);
    m_err  = (n > 0);
    m_cnt  = (n > 255) ? 8'd255 : 8'(n);
    m_wc   = 16'(exp_q.size());
    m_hb   = ((exp_q.size() >> 8) & 1) != 0;
  endtask

  task automatic check_model();
    logic m_seen, m_err, m_hb;
    logic [7:0] m_cnt;
    logic [W-1:0] m_exp, m_got;
    logic [15:0] m_wc;
    model_eval(m_seen, m_err, m_cnt, m_exp, m_got, m_wc, m_hb);
    chk("seen", seen0, m_seen);
    chk("err", err0, m_err);
    chk("errCount", cnt0, m_cnt);
    chk("errExp", eexp0, m_exp);
    chk("errGot", egot0, m_got);
    chk("wordCount", wc0, m_wc);
    chk("heartbeat", hb0, m_hb);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left on a negedge; drives one cycle of the dut0 read port.
  task automatic step0(input bit rok_v, input logic [W-1:0] rd_v, input bit use_model);
    if0.rok = rok_v;
    if0.rd  = rd_v;
    #1;
    chk("r_comb", if0.r, rok_v);
    @(posedge clk);
    if (rok_v) exp_q.push_back(rd_v);
    @(negedge clk);
    if (use_model) check_model();
  endtask

  task automatic do_reset();
    if0.rok = 1'b1;
    if0.rd  = 12'hABC;
    if1.rok = 1'b1;
    if1.rd  = 12'h0;
    rst_n   = 1'b0;
    #1;
    chk("rst_r0", if0.r, 0);
    chk("rst_r1", if1.r, 0);
    @(negedge clk);
    chk("rst_seen", seen0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_errExp", eexp0, 0);
    chk("rst_errGot", egot0, 0);
    chk("rst_wc", wc0, 0);
    chk("rst_hb", hb0, 0);
    chk("rst_wc1", wc1, 0);
    rst_n   = 1'b1;
    if0.rok = 1'b0;
    if1.rok = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           rst_before;
    bit           rok;
    logic [W-1:0] rd;
    bit           e_seen;
    bit           e_err;
    logic [7:0]   e_cnt;
    logic [W-1:0] e_exp;
    logic [W-1:0] e_got;
    logic [15:0]  e_wc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] v, last;
    bit rok_v, seeded, popped, found;
    int pulses, last_c;

    vecs[0]  = '{1'b1, 1'b1, 12'h005, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd1};
    vecs[1]  = '{1'b0, 1'b1, 12'h006, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd2};
    vecs[2]  = '{1'b0, 1'b1, 12'h007, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd3};
    vecs[3]  = '{1'b1, 1'b1, 12'hFFE, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd2};
    vecs[5]  = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd3};
    vecs[6]  = '{1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd4};
    vecs[7]  = '{1'b1, 1'b1, 12'h010, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd1};
    vecs[8]  = '{1'b0, 1'b1, 12'h011, 1'b1, 1'b0, 8'd0, 12'h000, 12'h000, 16'd2};
    vecs[9]  = '{1'b0, 1'b1, 12'h013, 1'b1, 1'b1, 8'd1, 12'h012, 12'h013, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 12'h014, 1'b1, 1'b1, 8'd1, 12'h012, 12'h013, 16'd4};
    vecs[11] = '{1'b0, 1'b0, 12'h777, 1'b1, 1'b1, 8'd1, 12'h012, 12'h013, 16'd4};

    rst_n   = 1'b0;
    if0.rok = 1'b0;
    if0.rd  = '0;
    if1.rok = 1'b0;
    if1.rd  = '0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_before) do_reset();
      step0(vecs[i].rok, vecs[i].rd, 1'b0);
      chk($sformatf("v%0d_seen", i), seen0, vecs[i].e_seen);
      chk($sformatf("v%0d_err", i), err0, vecs[i].e_err);
      chk($sformatf("v%0d_cnt", i), cnt0, vecs[i].e_cnt);
      chk($sformatf("v%0d_errExp", i), eexp0, vecs[i].e_exp);
      chk($sformatf("v%0d_errGot", i), egot0, vecs[i].e_got);
      chk($sformatf("v%0d_wc", i), wc0, vecs[i].e_wc);
      chk($sformatf("v%0d_hb", i), hb0, 0);
    end

    // Paced instance: one pop every 4 cycles with rok held high.
    do_reset();
    if1.rok = 1'b1;
    if1.rd  = 12'h100;
    pulses  = 0;
    last_c  = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      popped = if1.r;
      if (popped) begin
        pulses++;
        if (last_c >= 0) chk("pace_gap", c - last_c, 4);
        last_c = c;
      end
      @(negedge clk);
      if (popped) if1.rd = if1.rd + 12'd1;
    end
    chk("pace_pulses", pulses, 4);
    chk("pace_wc", wc1, 4);
    chk("pace_err", err1, 0);

    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (if1.r) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pace_find_hit", found, 1);
    if1.rok = 1'b0;
    #1;
    chk("drop_r", if1.r, 0);
    @(negedge clk);
    chk("drop_wc", wc1, 4);
    if1.rok = 1'b0;

    // 300 mismatching words after a seed: saturation, first-error hold, heartbeat at 256.
    do_reset();
    for (int i = 0; i < 301; i++) begin
      v = 12'(i * 2);
      step0(1'b1, v, 1'b0);
      if (i == 254) chk("hb_before_256", hb0, 0);
      if (i == 255) chk("hb_at_256", hb0, 1);
    end
    chk("sat_cnt", cnt0, 255);
    chk("sat_errExp", eexp0, 12'h001);
    chk("sat_errGot", egot0, 12'h002);
    chk("sat_wc", wc0, 301);
    check_model();

    // Reset asserted between edges mid-stream, then reseed.
    do_reset();
    step0(1'b1, 12'h050, 1'b0);
    step0(1'b1, 12'h052, 1'b0);
    chk("mid_err_before", err0, 1);
    if0.rok = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_r_async", if0.r, 0);
    chk("mid_wc_async", wc0, 0);
    chk("mid_err_async", err0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    step0(1'b1, 12'h123, 1'b1);
    step0(1'b1, 12'h124, 1'b1);
    chk("mid_err_after", err0, 0);
    chk("mid_wc_after", wc0, 2);
    chk("mid_state", st0, 1);

    // Randomized stream with gaps and occasional drops, crossing the 12-bit wrap.
    do_reset();
    seeded = 1'b0;
    last   = '0;
    for (int c = 0; c < 400; c++) begin
      rok_v = ($urandom_range(0, 3) != 0);
      if (rok_v) begin
        if (!seeded) begin
          v = 12'hF00 + 12'($urandom_range(0, 127));
          seeded = 1'b1;
        end else if ($urandom_range(0, 9) == 0) begin
          v = last + 12'($urandom_range(2, 5));
        end else begin
          v = last + 12'd1;
        end
        last = v;
      end else begin
        v = 12'($urandom_range(0, 4095));
      end
      step0(rok_v, v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
